// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the board input-conditioning path (switch sync/debounce).
package switch_debounce_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    // Short settle window keeps simulation fast; the board value gives ~10 us at 100 MHz.
    localparam int unsigned STABLE_CYCLES_SIM   = 4;
    localparam int unsigned STABLE_CYCLES_BOARD = 1000;

endpackage : switch_debounce_pkg

// File: rtl/switch_debounce_sync.sv
// Plain multi-flop synchroniser chain with synchronous reset, N_BITS wide.
module sync_chain #(
    parameter int unsigned N_BITS = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] d_i,
    output logic [N_BITS-1:0] q_o
);

    logic [N_BITS-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule : sync_chain

// File: rtl/switch_debounce.sv
// Synchronises and debounces {enable, data} switches as one vector for the priority encoder.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_BOARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             en_sw_in,
    output logic [WIDTH-1:0] x_out,
    output logic             en_out,
    output logic             changed,
    output logic             busy
);

    localparam int unsigned VW = WIDTH + 1;
    localparam int unsigned CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);

    logic [VW-1:0] s;
    state_e        state_q, state_d;
    logic [VW-1:0] cand_q, cand_d;
    logic [VW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          changed_q, changed_d;

    sync_chain #(
        .N_BITS (VW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({en_sw_in, sw_in}),
        .q_o (s)
    );

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s != out_q) begin
                    cand_d  = s;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Any movement of the synchronised vector restarts the window, even at terminal count.
                if (s != cand_q) begin
                    cand_d = s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d = IDLE;
                    if (cand_q != out_q) begin
                        out_d     = cand_q;
                        changed_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    assign x_out   = out_q[WIDTH-1:0];
    assign en_out  = out_q[WIDTH];
    assign changed = changed_q;
    assign busy    = (state_q == SETTLE);

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_in;
    logic       en_sw_in;
    logic [7:0] x_out;
    logic       en_out;
    logic       changed;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    switch_debounce #(
        .WIDTH         (8),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (STABLE_CYCLES_SIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_in    (sw_in),
        .en_sw_in (en_sw_in),
        .x_out    (x_out),
        .en_out   (en_out),
        .changed  (changed),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample 1 ns later; tally changed pulses seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (changed) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [7:0] s, input logic e);
        rst      = 1'b1;
        sw_in    = s;
        en_sw_in = e;
        ticks(3);
        rst      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset held with all switches on
        rst = 1'b1; sw_in = 8'hFF; en_sw_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_x", x_out, 8'h00);
            check_eq("rst_en", en_out, 1'b0);
            check_eq("rst_changed", changed, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
        end
        rst = 1'b0; pulses = 0;
        ticks(2);
        check_eq("rel_busy_e1", busy, 1'b0);
        tick();
        check_eq("rel_busy_e2", busy, 1'b1);
        ticks(3);
        check_eq("rel_x_e5", x_out, 8'h00);
        tick();
        check_eq("rel_x_e6", x_out, 8'hFF);
        check_eq("rel_en_e6", en_out, 1'b1);
        check_eq("rel_changed_e6", changed, 1'b1);
        tick();
        check_eq("rel_changed_e7", changed, 1'b0);
        check_eq("rel_pulses", pulses, 1);

        // Clean step {0,00} -> {1,90}
        do_reset(8'h00, 1'b0);
        check_eq("step_x0", x_out, 8'h00);
        pulses = 0; sw_in = 8'h90; en_sw_in = 1'b1;
        ticks(2);
        check_eq("step_busy_e1", busy, 1'b0);
        tick();
        check_eq("step_busy_e2", busy, 1'b1);
        ticks(3);
        check_eq("step_x_e5", x_out, 8'h00);
        check_eq("step_changed_e5", changed, 1'b0);
        tick();
        check_eq("step_x_e6", x_out, 8'h90);
        check_eq("step_en_e6", en_out, 1'b1);
        check_eq("step_changed_e6", changed, 1'b1);
        check_eq("step_busy_e6", busy, 1'b0);
        tick();
        check_eq("step_changed_e7", changed, 1'b0);

        // Bounce on bit 3, then hold 08
        do_reset(8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            sw_in = (i % 2 == 0) ? 8'h08 : 8'h00;
            ticks(2);
        end
        check_eq("bounce_pulses", pulses, 0);
        check_eq("bounce_x", x_out, 8'h00);
        sw_in = 8'h08;
        ticks(6);
        check_eq("bounce_x_e5", x_out, 8'h00);
        tick();
        check_eq("bounce_x_e6", x_out, 8'h08);
        check_eq("bounce_changed_e6", changed, 1'b1);
        ticks(3);
        check_eq("bounce_pulses_total", pulses, 1);

        // Bounce-back: one-cycle glitch to 00 from committed 08
        pulses = 0;
        sw_in = 8'h00;
        tick();
        sw_in = 8'h08;
        ticks(2);
        check_eq("bback_busy_e2", busy, 1'b1);
        ticks(4);
        check_eq("bback_busy_e6", busy, 1'b1);
        tick();
        check_eq("bback_busy_e7", busy, 1'b0);
        check_eq("bback_x", x_out, 8'h08);
        ticks(4);
        check_eq("bback_pulses", pulses, 0);
        check_eq("bback_x_end", x_out, 8'h08);

        // Staggered bits: 80 at edge 0, 81 at edge 3
        do_reset(8'h00, 1'b0);
        pulses = 0;
        sw_in = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stag_x_early", x_out, 8'h00);
        end
        sw_in = 8'h81;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("stag_x_hold", x_out, 8'h00);
        end
        tick();
        check_eq("stag_x_e9", x_out, 8'h81);
        check_eq("stag_changed_e9", changed, 1'b1);
        ticks(2);
        check_eq("stag_pulses", pulses, 1);

        // Reset in the middle of a settle window
        do_reset(8'h00, 1'b0);
        pulses = 0;
        sw_in = 8'h55;
        ticks(4);
        check_eq("mrst_busy_e3", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("mrst_busy", busy, 1'b0);
        check_eq("mrst_x", x_out, 8'h00);
        check_eq("mrst_changed", changed, 1'b0);
        rst = 1'b0;
        ticks(6);
        check_eq("mrst_x_e5", x_out, 8'h00);
        check_eq("mrst_pulses_pre", pulses, 0);
        tick();
        check_eq("mrst_x_e6", x_out, 8'h55);
        check_eq("mrst_changed_e6", changed, 1'b1);
        tick();
        check_eq("mrst_pulses", pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_switch_debounce
